// File: rtl/ewa_tile_feeder.sv
// Packs TILE_SIZE row pairs into an A/B tile for recfg_array element-wise modes (100/101/110).
// One-cycle valid_in pulse after the last row; row_ready stays low while a tile waits for done_tile.
module ewa_tile_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_SIZE  = 16,
  parameter int D_INNER    = 256,
  localparam int NUM_TILES = D_INNER / TILE_SIZE,
  localparam int IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [2:0]                             cfg_mode,
  input  logic                                   row_valid,
  output logic                                   row_ready,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]        row_a,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]        row_b,
  output logic [TILE_SIZE*TILE_SIZE*DATA_WIDTH-1:0] a_in,
  output logic [TILE_SIZE*TILE_SIZE*DATA_WIDTH-1:0] b_mat,
  output logic [TILE_SIZE*DATA_WIDTH-1:0]        b_vec,
  output logic [2:0]                             mode,
  output logic                                   valid_in,
  output logic                                   accumulate_en,
  input  logic                                   done_tile,
  output logic [IDX_W-1:0]                       tile_idx,
  output logic                                   busy,
  output logic                                   pass_done,
  output logic                                   cfg_err
);

  localparam int ROW_W = TILE_SIZE * DATA_WIDTH;
  localparam int RC_W  = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [2:0] MODE_VEC = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t            state;
  logic [RC_W-1:0]   row_cnt;
  logic [ROW_W-1:0]  a_row;
  logic [ROW_W-1:0]  b_row;
  logic [DATA_WIDTH-1:0] v_elem;
  logic              mode_ok;
  logic              row_fire;

  assign accumulate_en = 1'b0;
  assign mode_ok  = (cfg_mode == 3'b100) || (cfg_mode == 3'b101) || (cfg_mode == 3'b110);
  assign row_fire = row_valid && row_ready;

  // Vector mode keeps only lane 0 of each input row; the rest of the tile row is zeroed.
  always_comb begin
    a_row  = row_a;
    b_row  = row_b;
    v_elem = '0;
    if (mode == MODE_VEC) begin
      a_row  = {{(ROW_W-DATA_WIDTH){1'b0}}, row_a[DATA_WIDTH-1:0]};
      b_row  = '0;
      v_elem = row_b[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      tile_idx  <= '0;
      mode      <= '0;
      row_ready <= 1'b0;
      valid_in  <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      cfg_err   <= 1'b0;
      a_in      <= '0;
      b_mat     <= '0;
      b_vec     <= '0;
    end else begin
      valid_in  <= 1'b0;
      pass_done <= 1'b0;
      cfg_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (mode_ok) begin
              mode      <= cfg_mode;
              row_cnt   <= '0;
              tile_idx  <= '0;
              busy      <= 1'b1;
              row_ready <= 1'b1;
              state     <= S_FILL;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (row_fire) begin
            a_in[int'(row_cnt)*ROW_W +: ROW_W]             <= a_row;
            b_mat[int'(row_cnt)*ROW_W +: ROW_W]            <= b_row;
            b_vec[int'(row_cnt)*DATA_WIDTH +: DATA_WIDTH]  <= v_elem;
            if (row_cnt == RC_W'(TILE_SIZE-1)) begin
              row_ready <= 1'b0;
              valid_in  <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              row_cnt <= row_cnt + RC_W'(1);
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (done_tile) begin
            if (tile_idx == IDX_W'(NUM_TILES-1)) begin
              pass_done <= 1'b1;
              state     <= S_FIN;
            end else begin
              tile_idx  <= tile_idx + IDX_W'(1);
              row_cnt   <= '0;
              row_ready <= 1'b1;
              state     <= S_FILL;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ewa_tile_feeder.sv
// Randomized bench for ewa_tile_feeder: tiles are predicted from the row stream and compared at each valid_in.
module tb_ewa_tile_feeder;
  localparam int DW = 16, TS = 16, DI = 256, NT = DI / TS;
  localparam int ROW_W = TS * DW, TILE_W = TS * TS * DW;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, row_valid = 1'b0, done_tile = 1'b0;
  logic [2:0] cfg_mode = 3'b000;
  logic [ROW_W-1:0] row_a = '0, row_b = '0;
  logic row_ready, valid_in, accumulate_en, busy, pass_done, cfg_err;
  logic [TILE_W-1:0] a_in, b_mat;
  logic [ROW_W-1:0] b_vec;
  logic [2:0] mode;
  logic [3:0] tile_idx;

  logic [ROW_W-1:0] ra[DI];
  logic [ROW_W-1:0] rb[DI];
  int n_chk = 0, n_err = 0;

  ewa_tile_feeder #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .D_INNER(DI)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
    .row_valid(row_valid), .row_ready(row_ready), .row_a(row_a), .row_b(row_b),
    .a_in(a_in), .b_mat(b_mat), .b_vec(b_vec), .mode(mode), .valid_in(valid_in),
    .accumulate_en(accumulate_en), .done_tile(done_tile), .tile_idx(tile_idx),
    .busy(busy), .pass_done(pass_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane(input logic [ROW_W-1:0] r, input int k);
    return r[k*DW +: DW];
  endfunction

  // Tile t is rows t*TS .. t*TS+TS-1 of the stream; report the first differing element.
  task automatic check_tile(input int t, input logic [2:0] m);
    logic [DW-1:0] ea, eb, ev, ga, gb, gv;
    logic [DW-1:0] fa_g, fa_e, fb_g, fb_e, fv_g, fv_e;
    bit bad_a, bad_b, bad_v;
    bad_a = 0; bad_b = 0; bad_v = 0;
    fa_g = '0; fa_e = '0; fb_g = '0; fb_e = '0; fv_g = '0; fv_e = '0;
    for (int i = 0; i < TS; i++) begin
      ev = (m == 3'b100) ? lane(rb[t*TS+i], 0) : '0;
      gv = b_vec[i*DW +: DW];
      if (i == 0 || (gv !== ev && !bad_v)) begin fv_g = gv; fv_e = ev; if (gv !== ev) bad_v = 1; end
      for (int j = 0; j < TS; j++) begin
        if (m == 3'b100) begin
          ea = (j == 0) ? lane(ra[t*TS+i], 0) : '0;
          eb = '0;
        end else begin
          ea = lane(ra[t*TS+i], j);
          eb = lane(rb[t*TS+i], j);
        end
        ga = a_in[(i*TS+j)*DW +: DW];
        gb = b_mat[(i*TS+j)*DW +: DW];
        if ((i == 0 && j == 0) || (ga !== ea && !bad_a)) begin fa_g = ga; fa_e = ea; if (ga !== ea) bad_a = 1; end
        if ((i == 0 && j == 0) || (gb !== eb && !bad_b)) begin fb_g = gb; fb_e = eb; if (gb !== eb) bad_b = 1; end
      end
    end
    chk("a_in", fa_g, fa_e);
    chk("b_mat", fb_g, fb_e);
    chk("b_vec", fv_g, fv_e);
    chk("mode", mode, m);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_row_ready"}, row_ready, 0);
    chk({tag, "_valid_in"}, valid_in, 0);
    chk({tag, "_pass_done"}, pass_done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_tile_idx"}, tile_idx, 0);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_acc_en"}, accumulate_en, 0);
    chk({tag, "_tiles"}, |{a_in, b_mat, b_vec}, 0);
  endtask

  // vmode: 0 always valid, 1 toggled, 2 random. abort_tile<0 disables the mid-pass reset.
  task automatic run_pass(input logic [2:0] m, input int vmode, input int ddly,
                          input int abort_tile, input bit spur, input bit bstart);
    int ridx, tdone, wcnt, cyc;
    bit issued, fire, dreal, hold_bad;
    logic [TILE_W-1:0] snap_a, snap_b;
    logic [ROW_W-1:0] snap_v;
    ridx = 0; tdone = 0; wcnt = 0; issued = 0; fire = 0; dreal = 0; hold_bad = 0;
    snap_a = '0; snap_b = '0; snap_v = '0;
    @(negedge clk); start = 1'b1; cfg_mode = m;
    @(negedge clk); start = 1'b0; cfg_mode = 3'($urandom);
    chk("start_busy", busy, 1);
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (fire) ridx++;
      if (dreal) begin
        tdone++; issued = 0;
        chk("hold_stable", hold_bad, 0);
        hold_bad = 0;
      end
      if (start) begin
        start = 1'b0;
        chk("busy_start_err", cfg_err, 0);
      end
      done_tile = 1'b0; dreal = 0;
      if (tdone == NT) break;
      chk("busy", busy, 1);
      chk("tile_idx", tile_idx, tdone);
      chk("row_ready", row_ready, ridx < TS*(tdone+1));
      chk("valid_in", valid_in, (ridx == TS*(tdone+1)) && !issued);
      if (valid_in) begin
        issued = 1;
        check_tile(tdone, m);
        snap_a = a_in; snap_b = b_mat; snap_v = b_vec;
        wcnt = ddly;
        if (spur) done_tile = 1'b1;  // lands in the issue cycle and must be ignored
      end else if (issued) begin
        if (a_in !== snap_a || b_mat !== snap_b || b_vec !== snap_v || mode !== m) hold_bad = 1;
        if (tdone == abort_tile) begin
          #1 rst = 1'b1;
          #1 check_all_zero("abort");
          row_valid = 1'b0; done_tile = 1'b0; start = 1'b0;
          @(negedge clk); rst = 1'b0;
          return;
        end
        wcnt--;
        if (wcnt == 0) begin done_tile = 1'b1; dreal = 1; end
      end else if (spur && row_ready && ridx % TS == 5) begin
        done_tile = 1'b1;
      end else if (bstart && tdone == 3 && ridx % TS == 2) begin
        start = 1'b1; cfg_mode = 3'b100;
      end
      case (vmode)
        0:       row_valid = 1'b1;
        1:       row_valid = (cyc % 2 == 1);
        default: row_valid = ($urandom_range(3) != 0);
      endcase
      row_a = ra[ridx % DI];
      row_b = rb[ridx % DI];
      fire = row_valid && row_ready;
    end
    row_valid = 1'b0;
    chk("tiles_done", tdone, NT);
    chk("rows_taken", ridx, DI);
    chk("pass_done", pass_done, 1);
    chk("busy_fin", busy, 1);
    @(negedge clk);
    chk("pass_done_pulse", pass_done, 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < DI; r++)
      for (int k = 0; k < TS; k++) begin
        ra[r][k*DW +: DW] = DW'($urandom);
        rb[r][k*DW +: DW] = DW'($urandom);
      end
  endtask

  initial begin
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Rejected mode: error pulse only, no pass.
    @(negedge clk); start = 1'b1; cfg_mode = 3'b011;
    @(negedge clk); start = 1'b0;
    chk("bad_cfg_err", cfg_err, 1);
    chk("bad_cfg_busy", busy, 0);
    @(negedge clk);
    chk("bad_cfg_err_pulse", cfg_err, 0);
    chk("bad_cfg_valid", valid_in, 0);
    chk("bad_cfg_ready", row_ready, 0);

    for (int r = 0; r < DI; r++) begin
      ra[r] = {{(TS-1){16'h7FFF}}, DW'(r - 4)};
      rb[r] = {{(TS-1){16'h7FFF}}, 16'd3};
    end
    run_pass(3'b100, 0, 1, -1, 0, 0);

    for (int r = 0; r < DI; r++)
      for (int k = 0; k < TS; k++) begin
        ra[r][k*DW +: DW] = DW'(r*16 + k);
        rb[r][k*DW +: DW] = DW'(-(r*16 + k));
      end
    run_pass(3'b101, 2, 7, -1, 0, 1);

    fill_random();
    run_pass(3'b110, 1, 2, -1, 0, 0);

    fill_random();
    run_pass(3'b101, 2, 3, 5, 1, 0);

    fill_random();
    run_pass(3'b110, 0, 1, -1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ewa_tile_feeder.md
Name: ewa_tile_feeder

Overview:
- Upstream operand packer for recfg_array in its element-wise modes: 3'b100 (EWA-vector y = C_h + D_x), 3'b101 (EWA-matrix h_t = A_ht-1 + ΔB_x) and 3'b110 (EWM-matrix EXP_ΔA ⊙ h_t-1).
- Accepts one row pair (operand A row, operand B row) per handshake from the scan-state buffers and assembles TILE_SIZE rows into a tile.
- Fires a single-cycle valid_in to the array, then holds the tile stable until done_tile returns.
- Repeats for D_INNER/TILE_SIZE tiles per pass.

Parameters:
- DATA_WIDTH, 16, element width (signed).
- TILE_SIZE, 16, rows/cols per tile; equals D_STATE.
- D_INNER, 256, rows per pass; must be a multiple of TILE_SIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  pulse; begins a pass with cfg_mode.
- cfg_mode  in  3  pass mode, latched on accepted start.
- row_valid  in  1  row pair available.
- row_ready  out  1  feeder accepts row pair this cycle.
- row_a  in  TILE_SIZE*DATA_WIDTH  operand A row; lane k at bits [k*DW +: DW].
- row_b  in  TILE_SIZE*DATA_WIDTH  operand B row, same lane layout.
- a_in  out  TILE_SIZE*TILE_SIZE*DATA_WIDTH  tile A; element [i][j] at index i*TILE_SIZE+j.
- b_mat  out  TILE_SIZE*TILE_SIZE*DATA_WIDTH  tile B, matrix modes.
- b_vec  out  TILE_SIZE*DATA_WIDTH  vector B, mode 100.
- mode  out  3  mode to array.
- valid_in  out  1  tile-issue pulse to array.
- accumulate_en  out  1  tied 0.
- done_tile  in  1  array finished current tile.
- tile_idx  out  log2(D_INNER/TILE_SIZE)  index of the tile being filled or issued.
- busy  out  1  pass in progress.
- pass_done  out  1  one-cycle pulse after the last tile completes.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset values: all outputs 0; tile registers 0; state IDLE.
- Reset mid-pass aborts immediately. No pass_done is issued.
- FSM states: IDLE, FILL, ISSUE, WAIT, FIN.
- IDLE:
  - start with cfg_mode in {100, 101, 110}: latch mode, clear row_cnt and tile_idx, go to FILL, busy=1.
  - start with any other cfg_mode: cfg_err=1 next cycle, stay IDLE.
  - start while busy is ignored, with no error.
- FILL:
  - row_ready=1; a row is accepted when row_valid && row_ready.
  - Row r = row_cnt of the tile, for modes 101/110: a_in[r][*]=row_a, b_mat[r][*]=row_b, b_vec[r]=0.
  - Row r, for mode 100: a_in[r][0]=row_a lane0, a_in[r][1..]=0, b_vec[r]=row_b lane0, b_mat[r][*]=0. Lanes 1..TILE_SIZE-1 of the inputs are ignored.
  - On accepting row TILE_SIZE-1, go to ISSUE; row_ready drops the next cycle.
- ISSUE: valid_in=1 for exactly one cycle (the cycle after the last row is accepted); go to WAIT.
- WAIT:
  - row_ready=0; a_in, b_mat, b_vec and mode are held constant until done_tile is seen.
  - done_tile sampled 1: if tile_idx == D_INNER/TILE_SIZE-1 go to FIN, else increment tile_idx, clear row_cnt, go to FILL.
  - done_tile on the same cycle valid_in is high is ignored; the done must arrive in WAIT.
- FIN: pass_done=1 for one cycle; busy=0 and go to IDLE the next cycle.
- done_tile outside WAIT is ignored.
- Tile registers keep their last values after the pass; there is no clearing between tiles, since every row is rewritten.
- No arithmetic; pure data movement. Signed values pass bit-exact.
- Throughput: TILE_SIZE+1 cycles plus array latency per tile. No double buffering.

Test Plan:
- Mode 100, rows where row_a lane0 = r-4 and row_b lane0 = 3 (other lanes 0x7FFF): 16 valid_in pulses; tile 0 a_in[i][0]=i-4, a_in[i][1..15]=0, b_vec[i]=3, b_mat all 0; pass_done after the 16th done_tile.
- Mode 101, row_a lane k = r*16+k, row_b = -row_a: each tile has a_in[i][j] = (t*16+i)*16+j, b_mat = its negation; operands unchanged from valid_in until done_tile delayed 7 cycles.
- Mode 110 with row_valid toggled every other cycle: tile contents match the uninterrupted case; valid_in occurs only after all 16 rows are accepted; row_ready=0 during WAIT.
- cfg_mode=3'b011 start: cfg_err pulses, busy stays 0, no valid_in. A start during an active pass has no effect.
- Spurious done_tile during FILL: tile_idx unchanged and no extra issue. rst asserted during WAIT of tile 5: all outputs 0 immediately; a fresh start restarts at tile_idx 0.
